opb_fwd_stage: RTL

//   Next-generation operand-B path for the pipelined core.

---
 rtl/opb_fwd_stage.sv | 88 ++++++++
 1 files changed

// File: rtl/opb_fwd_stage.sv
// rtl/opb_fwd_stage.sv - operand-B select with rs2 forwarding, registered into the ID/EX boundary
module opb_fwd_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_opb_sel,
    input  logic [XLEN-1:0]         i_imm,
    input  logic [4:0]              i_rs2_addr,
    input  logic [XLEN-1:0]         i_rs2_data,
    input  logic [NUM_FWD-1:0]      i_fwd_we,
    input  logic [NUM_FWD*5-1:0]    i_fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
    output logic                    o_valid,
    output logic [XLEN-1:0]         o_operand_b,
    output logic [XLEN-1:0]         o_rs2_fwd,
    output logic [NUM_FWD-1:0]      o_fwd_hit,
    output logic [CNT_W-1:0]        o_fwd_cnt
);

    logic [NUM_FWD-1:0] hit;
    logic [NUM_FWD-1:0] sel_hit;
    logic [XLEN-1:0]    rs2_res;
    logic [XLEN-1:0]    opb_res;
    logic               cnt_sat;

    // Raw address match per source; x0 is hardwired zero and never forwarded
    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            hit[k] = i_fwd_we[k] && (i_fwd_addr[5*k +: 5] == i_rs2_addr) && (i_rs2_addr != 5'd0);
        end
    end

    // Priority pick: scan oldest to youngest so the lowest index is written last and wins
    always_comb begin
        sel_hit = '0;
        rs2_res = i_rs2_data;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel_hit    = '0;
                sel_hit[k] = 1'b1;
                rs2_res    = i_fwd_data[XLEN*k +: XLEN];
            end
        end
    end

    // Operand B mux; rs2 is still resolved when the immediate is selected since stores need it
    always_comb begin
        opb_res = i_opb_sel ? i_imm : rs2_res;
        cnt_sat = (o_fwd_cnt == {CNT_W{1'b1}});
    end

    // ID/EX entry register: reset > flush > stall > load
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_operand_b <= '0;
            o_rs2_fwd   <= '0;
            o_fwd_hit   <= '0;
        end else if (i_flush) begin
            o_valid     <= 1'b0;
            o_operand_b <= '0;
            o_rs2_fwd   <= '0;
            o_fwd_hit   <= '0;
        end else if (!i_stall) begin
            o_valid     <= i_valid;
            o_operand_b <= opb_res;
            o_rs2_fwd   <= rs2_res;
            o_fwd_hit   <= i_valid ? sel_hit : '0;
        end
    end

    // Saturating count of valid loads whose rs2 came from a forwarding source
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fwd_cnt <= '0;
        end else if (!i_flush && !i_stall && i_valid && (|sel_hit) && !cnt_sat) begin
            o_fwd_cnt <= o_fwd_cnt + CNT_W'(1);
        end
    end

endmodule
